// File: rtl/apb_shared_arbiter.sv
// Two-requester APB arbiter. Each transaction is granted whole, round-robin, and replayed on a
// single downstream APB port. A wait-state timeout aborts the transfer if the slave hangs.
module apb_shared_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,

  input  logic              s0_PSEL,
  input  logic              s0_PENABLE,
  input  logic [ADDR_W-1:0] s0_PADDR,
  input  logic              s0_PWRITE,
  input  logic [DATA_W-1:0] s0_PWDATA,
  output logic [DATA_W-1:0] s0_PRDATA,
  output logic              s0_PREADY,
  output logic              s0_PSLVERR,

  input  logic              s1_PSEL,
  input  logic              s1_PENABLE,
  input  logic [ADDR_W-1:0] s1_PADDR,
  input  logic              s1_PWRITE,
  input  logic [DATA_W-1:0] s1_PWDATA,
  output logic [DATA_W-1:0] s1_PRDATA,
  output logic              s1_PREADY,
  output logic              s1_PSLVERR,

  output logic              m_PSEL,
  output logic              m_PENABLE,
  output logic [ADDR_W-1:0] m_PADDR,
  output logic              m_PWRITE,
  output logic [DATA_W-1:0] m_PWDATA,
  input  logic [DATA_W-1:0] m_PRDATA,
  input  logic              m_PREADY,
  input  logic              m_PSLVERR,

  output logic [1:0]        gnt,
  output logic              timeout_err
);

  localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned     CntW      = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLimit  = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            r_state,   w_state_d;
  logic [1:0]        r_gnt,     w_gnt_d;
  logic              r_prio,    w_prio_d;     // 1: s1 holds priority
  logic [CntW-1:0]   r_cnt,     w_cnt_d;
  logic              r_valid,   w_valid_d;    // granted requester still holding PSEL
  logic              r_psel,    w_psel_d;
  logic              r_penable, w_penable_d;
  logic [ADDR_W-1:0] r_addr,    w_addr_d;
  logic              r_write,   w_write_d;
  logic [DATA_W-1:0] r_wdata,   w_wdata_d;
  logic [DATA_W-1:0] r_rdata,   w_rdata_d;
  logic              r_slverr,  w_slverr_d;
  logic              r_timeout, w_timeout_d;

  logic [1:0]        w_req;
  logic [1:0]        w_pick;
  logic              w_gnt_sel;
  logic [CntW-1:0]   w_cnt_inc;
  logic              w_resp;
  logic              w_unused_penable;

  // Arbitration depends only on PSEL; upstream PENABLE carries no extra information here.
  assign w_unused_penable = s0_PENABLE | s1_PENABLE;

  assign w_req     = {s1_PSEL, s0_PSEL};
  assign w_pick    = (&w_req) ? (r_prio ? 2'b10 : 2'b01) : w_req;
  assign w_gnt_sel = |(r_gnt & w_req);
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_d   = r_state;
    w_gnt_d     = r_gnt;
    w_prio_d    = r_prio;
    w_cnt_d     = r_cnt;
    w_valid_d   = r_valid;
    w_psel_d    = r_psel;
    w_penable_d = r_penable;
    w_addr_d    = r_addr;
    w_write_d   = r_write;
    w_wdata_d   = r_wdata;
    w_rdata_d   = r_rdata;
    w_slverr_d  = r_slverr;
    w_timeout_d = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (|w_req) begin
          w_gnt_d     = w_pick;
          w_valid_d   = 1'b1;
          w_addr_d    = w_pick[1] ? s1_PADDR  : s0_PADDR;
          w_write_d   = w_pick[1] ? s1_PWRITE : s0_PWRITE;
          w_wdata_d   = w_pick[1] ? s1_PWDATA : s0_PWDATA;
          w_psel_d    = 1'b1;
          w_penable_d = 1'b0;
          w_state_d   = StSetup;
        end
      end

      StSetup: begin
        if (!w_gnt_sel) w_valid_d = 1'b0;
        w_penable_d = 1'b1;
        w_state_d   = StAccess;
      end

      StAccess: begin
        if (!w_gnt_sel) w_valid_d = 1'b0;
        if (m_PREADY) begin
          // A ready slave wins even on the cycle the counter would hit the limit.
          w_rdata_d   = m_PRDATA;
          w_slverr_d  = m_PSLVERR;
          w_psel_d    = 1'b0;
          w_penable_d = 1'b0;
          w_state_d   = StResp;
        end else if (TimeoutEn) begin
          w_cnt_d = w_cnt_inc;
          if (w_cnt_inc == CntLimit) begin
            w_rdata_d   = '0;
            w_slverr_d  = 1'b1;
            w_timeout_d = 1'b1;
            w_psel_d    = 1'b0;
            w_penable_d = 1'b0;
            w_state_d   = StResp;
          end
        end
      end

      StResp: begin
        w_prio_d  = r_gnt[0];
        w_gnt_d   = 2'b00;
        w_cnt_d   = '0;
        w_valid_d = 1'b0;
        w_state_d = StIdle;
      end

      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= StIdle;
      r_gnt     <= 2'b00;
      r_prio    <= 1'b0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_gnt     <= w_gnt_d;
      r_prio    <= w_prio_d;
      r_cnt     <= w_cnt_d;
      r_valid   <= w_valid_d;
      r_psel    <= w_psel_d;
      r_penable <= w_penable_d;
      r_addr    <= w_addr_d;
      r_write   <= w_write_d;
      r_wdata   <= w_wdata_d;
      r_rdata   <= w_rdata_d;
      r_slverr  <= w_slverr_d;
      r_timeout <= w_timeout_d;
    end
  end

  assign w_resp = (r_state == StResp) && r_valid;

  assign s0_PREADY  = w_resp & r_gnt[0];
  assign s0_PRDATA  = s0_PREADY ? r_rdata : '0;
  assign s0_PSLVERR = s0_PREADY & r_slverr;

  assign s1_PREADY  = w_resp & r_gnt[1];
  assign s1_PRDATA  = s1_PREADY ? r_rdata : '0;
  assign s1_PSLVERR = s1_PREADY & r_slverr;

  assign m_PSEL      = r_psel;
  assign m_PENABLE   = r_penable;
  assign m_PADDR     = r_addr;
  assign m_PWRITE    = r_write;
  assign m_PWDATA    = r_wdata;
  assign gnt         = r_gnt;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_apb_shared_arbiter.sv
// Directed bench for apb_shared_arbiter: upstream masters fed from request queues, a configurable
// slave, and a response scoreboard checked whenever an upstream PREADY appears.
module tb_apb_shared_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        s0_PSEL = 1'b0, s0_PENABLE = 1'b0, s0_PWRITE = 1'b0;
  logic [31:0] s0_PADDR = '0, s0_PWDATA = '0;
  logic        s1_PSEL = 1'b0, s1_PENABLE = 1'b0, s1_PWRITE = 1'b0;
  logic [31:0] s1_PADDR = '0, s1_PWDATA = '0;
  logic [31:0] s0_PRDATA, s1_PRDATA, m_PADDR, m_PWDATA, m_PRDATA;
  logic        s0_PREADY, s0_PSLVERR, s1_PREADY, s1_PSLVERR;
  logic        m_PSEL, m_PENABLE, m_PWRITE, m_PREADY, m_PSLVERR, timeout_err;
  logic [1:0]  gnt;

  apb_shared_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .s0_PSEL(s0_PSEL), .s0_PENABLE(s0_PENABLE), .s0_PADDR(s0_PADDR), .s0_PWRITE(s0_PWRITE),
    .s0_PWDATA(s0_PWDATA), .s0_PRDATA(s0_PRDATA), .s0_PREADY(s0_PREADY),
    .s0_PSLVERR(s0_PSLVERR),
    .s1_PSEL(s1_PSEL), .s1_PENABLE(s1_PENABLE), .s1_PADDR(s1_PADDR), .s1_PWRITE(s1_PWRITE),
    .s1_PWDATA(s1_PWDATA), .s1_PRDATA(s1_PRDATA), .s1_PREADY(s1_PREADY),
    .s1_PSLVERR(s1_PSLVERR),
    .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE), .m_PADDR(m_PADDR), .m_PWRITE(m_PWRITE),
    .m_PWDATA(m_PWDATA), .m_PRDATA(m_PRDATA), .m_PREADY(m_PREADY), .m_PSLVERR(m_PSLVERR),
    .gnt(gnt), .timeout_err(timeout_err)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {logic [31:0] addr; logic wr; logic [31:0] wdata;} req_t;
  typedef struct packed {logic port; logic [31:0] rdata; logic slverr; logic to;} exp_t;

  req_t q0[$];
  req_t q1[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int unsigned slv_wait  = 0;
  int unsigned acc_cnt   = 0;
  logic        slv_hang  = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  logic        p0 = 1'b0, p1 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Slave: ready after slv_wait ACCESS cycles unless hung.
  assign m_PREADY  = m_PSEL && m_PENABLE && !slv_hang && (acc_cnt >= slv_wait);
  assign m_PRDATA  = slv_rdata;
  assign m_PSLVERR = slv_err;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) acc_cnt <= 0;
    else if (m_PSEL && m_PENABLE && !m_PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // Monitor and scoreboard compare.
  always @(negedge PCLK) begin
    exp_t e;
    p0 = s0_PREADY;
    p1 = s1_PREADY;
    if (s0_PREADY || s1_PREADY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pready", {s1_PREADY, s0_PREADY}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port", {s1_PREADY, s0_PREADY}, e.port ? 2'b10 : 2'b01);
        chk("resp_rdata", e.port ? s1_PRDATA : s0_PRDATA, e.rdata);
        chk("resp_slverr", e.port ? s1_PSLVERR : s0_PSLVERR, e.slverr);
        chk("resp_timeout_err", timeout_err, e.to);
      end
    end else begin
      chk("idle_timeout_err", timeout_err, 1'b0);
    end
    if (!gnt[0]) chk("s0_ungranted_quiet", {s0_PREADY, s0_PSLVERR, s0_PRDATA}, '0);
    if (!gnt[1]) chk("s1_ungranted_quiet", {s1_PREADY, s1_PSLVERR, s1_PRDATA}, '0);
  end

  // Upstream masters: hold PSEL until PREADY, then start the next queued request.
  always @(posedge PCLK) begin
    req_t r;
    #1;
    if (!PRESETn) begin
      s0_PSEL = 1'b0; s0_PENABLE = 1'b0;
      s1_PSEL = 1'b0; s1_PENABLE = 1'b0;
    end else begin
      if (p0) begin s0_PSEL = 1'b0; s0_PENABLE = 1'b0; end
      else if (s0_PSEL) s0_PENABLE = 1'b1;
      if (!s0_PSEL && q0.size() > 0) begin
        r = q0.pop_front();
        s0_PSEL = 1'b1; s0_PENABLE = 1'b0;
        s0_PADDR = r.addr; s0_PWRITE = r.wr; s0_PWDATA = r.wdata;
      end
      if (p1) begin s1_PSEL = 1'b0; s1_PENABLE = 1'b0; end
      else if (s1_PSEL) s1_PENABLE = 1'b1;
      if (!s1_PSEL && q1.size() > 0) begin
        r = q1.pop_front();
        s1_PSEL = 1'b1; s1_PENABLE = 1'b0;
        s1_PADDR = r.addr; s1_PWRITE = r.wr; s1_PWDATA = r.wdata;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_ctrl"}, {m_PSEL, m_PENABLE, m_PWRITE}, 3'b000);
    chk({tag, "_m_paddr"}, m_PADDR, 32'h0);
    chk({tag, "_m_pwdata"}, m_PWDATA, 32'h0);
    chk({tag, "_s0"}, {s0_PREADY, s0_PSLVERR, s0_PRDATA}, '0);
    chk({tag, "_s1"}, {s1_PREADY, s1_PSLVERR, s1_PRDATA}, '0);
    chk({tag, "_gnt_to"}, {gnt, timeout_err}, 3'b000);
  endtask

  initial begin
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    chk_all_zero("reset");
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    // Single zero-wait write from s0.
    q0.push_back('{addr: 32'h4000_0100, wr: 1'b1, wdata: 32'hDEAD_BEEF});
    exp_q.push_back('{port: 1'b0, rdata: 32'h0, slverr: 1'b0, to: 1'b0});
    @(negedge PCLK);
    chk("t1_c0_idle", {m_PSEL, gnt}, 3'b000);
    @(negedge PCLK);
    chk("t1_c1_ctrl", {m_PSEL, m_PENABLE, m_PWRITE}, 3'b101);
    chk("t1_c1_gnt", gnt, 2'b01);
    chk("t1_c1_paddr", m_PADDR, 32'h4000_0100);
    chk("t1_c1_pwdata", m_PWDATA, 32'hDEAD_BEEF);
    @(negedge PCLK);
    chk("t1_c2_ctrl", {m_PSEL, m_PENABLE}, 2'b11);
    chk("t1_c2_gnt", gnt, 2'b01);
    @(negedge PCLK);
    chk("t1_c3_pready", s0_PREADY, 1'b1);
    chk("t1_c3_msel", m_PSEL, 1'b0);
    @(negedge PCLK);
    chk("t1_c4_idle", {s0_PREADY, gnt}, 3'b000);

    // s1 read with three downstream wait states.
    slv_wait = 3; slv_rdata = 32'h0000_1234;
    q1.push_back('{addr: 32'h4000_0204, wr: 1'b0, wdata: 32'h0});
    exp_q.push_back('{port: 1'b1, rdata: 32'h0000_1234, slverr: 1'b0, to: 1'b0});
    repeat (6) @(negedge PCLK);
    chk("t2_c5_pready", s1_PREADY, 1'b0);
    @(negedge PCLK);
    chk("t2_c6_pready", s1_PREADY, 1'b1);
    chk("t2_c6_prdata", s1_PRDATA, 32'h0000_1234);
    @(negedge PCLK);

    // Simultaneous requests: alternate s0, s1, s0, s1 at one per 4 cycles.
    slv_wait = 0; slv_rdata = 32'h0000_00A5;
    q0.push_back('{addr: 32'h10, wr: 1'b1, wdata: 32'h1});
    q0.push_back('{addr: 32'h14, wr: 1'b0, wdata: 32'h2});
    q1.push_back('{addr: 32'h20, wr: 1'b1, wdata: 32'h3});
    q1.push_back('{addr: 32'h24, wr: 1'b0, wdata: 32'h4});
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{port: i[0], rdata: 32'h0000_00A5, slverr: 1'b0, to: 1'b0});
    repeat (15) @(negedge PCLK);
    #1;
    chk("t3_c14_pending", exp_q.size(), 1);
    @(negedge PCLK);
    #1;
    chk("t3_c15_drained", exp_q.size(), 0);

    // Hung slave: abort after 16 ACCESS cycles.
    slv_hang = 1'b1; slv_rdata = 32'hBAD0_BAD0;
    q0.push_back('{addr: 32'h30, wr: 1'b0, wdata: 32'h0});
    exp_q.push_back('{port: 1'b0, rdata: 32'h0, slverr: 1'b1, to: 1'b1});
    repeat (18) @(negedge PCLK);
    chk("t4_c17_access", {m_PSEL, m_PENABLE, s0_PREADY, timeout_err}, 4'b1100);
    @(negedge PCLK);
    chk("t4_c18_resp", {m_PSEL, s0_PREADY, timeout_err}, 3'b011);
    @(negedge PCLK);
    chk("t4_c19_idle", {timeout_err, gnt}, 3'b000);

    // Ready on the 16th ACCESS cycle beats the timeout.
    slv_hang = 1'b0; slv_wait = 15; slv_rdata = 32'h0000_5A5A;
    q0.push_back('{addr: 32'h34, wr: 1'b0, wdata: 32'h0});
    exp_q.push_back('{port: 1'b0, rdata: 32'h0000_5A5A, slverr: 1'b0, to: 1'b0});
    repeat (19) @(negedge PCLK);
    chk("t5_c18_pready", s0_PREADY, 1'b1);
    @(negedge PCLK);

    // Reset during ACCESS: everything drops at once, priority returns to s0.
    slv_hang = 1'b1;
    q0.push_back('{addr: 32'h40, wr: 1'b1, wdata: 32'hCAFE_F00D});
    repeat (3) @(negedge PCLK);
    chk("t6_access", {m_PSEL, m_PENABLE, gnt}, 4'b1101);
    #2 PRESETn = 1'b0;
    #1 chk_all_zero("mid_reset");
    repeat (2) @(negedge PCLK);
    slv_hang = 1'b0; slv_wait = 0; slv_rdata = 32'h0000_0077;
    PRESETn = 1'b1;
    q0.push_back('{addr: 32'h50, wr: 1'b0, wdata: 32'h0});
    q1.push_back('{addr: 32'h54, wr: 1'b0, wdata: 32'h0});
    exp_q.push_back('{port: 1'b0, rdata: 32'h0000_0077, slverr: 1'b0, to: 1'b0});
    exp_q.push_back('{port: 1'b1, rdata: 32'h0000_0077, slverr: 1'b0, to: 1'b0});
    repeat (2) @(negedge PCLK);
    chk("t6_first_gnt", gnt, 2'b01);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge PCLK);
    chk("final_drain", exp_q.size(), 0);
    repeat (2) @(negedge PCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
